tagged_register_file: RTL and testbench
=======================================

// Module: tagged_register_file
// PURPOSE
//   Architectural register file with Tomasulo register-status tags. It sits upstream of every reservation station.
//   - Issue stage reads rs/rt as 36-bit operands {ready, source device, value}; these drive in_valueA / in_valueB.
//   - Issue stage marks rd as pending on the issuing device.
//   - The file snoops the CDB and retires pending registers when their producing device broadcasts.
// PARAMETERS
//   NREG    32  number of registers; index 0 is hard-wired to zero
//   DATA_W  32  data width
//   TAG_W   3   device-number width; tag 0 = no producer
// PORTS
//   clk          in   1                 rising-edge clock
//   rst          in   1                 asynchronous, active-high reset
//   rd_addr_a    in   5                 read port A register index (rs)
//   rd_addr_b    in   5                 read port B register index (rt)
//   rd_opnd_a    out  DATA_W+TAG_W+1    {ready, tag, value} for port A (combinational)
//   rd_opnd_b    out  DATA_W+TAG_W+1    {ready, tag, value} for port B (combinational)
//   iss_valid    in   1                 an instruction issues this cycle and writes rd
//   iss_rd       in   5                 destination register of the issuing instruction
//   iss_device   in   TAG_W             device number that will produce rd
//   cdb_buzy     in   1                 CDB carries a valid result this cycle
//   cdb_device   in   TAG_W             device currently driving the CDB
//   cdb_value    in   DATA_W            value on the CDB
//   dbg_addr     in   5                 testbench/debug read index
//   dbg_value    out  DATA_W            committed value of dbg_addr (no forwarding)
//   all_ready    out  1                 no register is pending (pipeline drained)
// BEHAVIOUR
//   - State per register: value[DATA_W], ready, tag[TAG_W].
//   - Reset (async): all values 0, ready=1, tag=0. Consequences: rd_opnd_* = {1,0,0}, dbg_value = 0, all_ready = 1.
//   - Read is combinational, evaluated in priority order:
//     1. addr 0 -> {1,0,0}.
//     2. ready=1 -> {1,0,value}.
//     3. ready=0 and cdb_buzy and cdb_device==tag -> {1,0,cdb_value}. This same-cycle forward is required:
//        stations latch operands at the edge where the broadcast ends and would otherwise miss it.
//     4. otherwise -> {0,tag,0}.
//   - Reads always see pre-edge state. An issue reading and writing the same register (add $1,$1,$2)
//     gets the old producer or value for its source operand.
//   - Issue write (edge, iss_valid=1, iss_rd!=0): ready<=0, tag<=iss_device; value is unchanged.
//     iss_rd==0 is ignored.
//   - CDB retire (edge, cdb_buzy=1): every register with ready=0 and tag==cdb_device gets
//     value<=cdb_value, ready<=1, tag<=0. Several registers may retire on one broadcast.
//   - Simultaneous issue and retire on the same register: the issue wins. The new tag is kept,
//     the CDB value is discarded, ready stays 0 (WAW: the older result is dead).
//   - Retire of other registers proceeds normally in the same cycle.
//   - cdb_device==0 with cdb_buzy=1 is illegal and is ignored (no register carries tag 0 while pending).
//   - A tag is never shared by two live producers: devices accept one instruction at a time,
//     so the latest issue owns the tag.
//   - all_ready = AND of all ready bits, registered state only (no forwarding).
//   - dbg_value reads stored value only. A pending register shows its stale value.
//   - No internal latency beyond one edge: a broadcast at cycle N is visible as stored ready at N+1
//     and forwarded at N.
// STRUCTURE
//   - Shared include: device numbers (DEVICE_ADDER=1, DEVICE_LOGIC=2, DEVICE_DM=3, DEVICE_JMP=7)
//     and 36-bit operand field macros (OPND_READY=35, OPND_TAG=34:32, OPND_VALUE=31:0).
//   - One sub-module, reg_status_entry: a single register with value/ready/tag, its issue and
//     retire update logic, and its own async reset. It is instantiated NREG-1 times via generate.
//   - Top level holds the read muxes, forwarding, all_ready reduction and the debug port.
// TESTING
//   - Reset mid-run: pend $3 on device 1, assert rst asynchronously between edges.
//     -> rd_opnd immediately {1,0,0}; all_ready=1.
//   - Issue $5 on device 1 (adder); next cycle read $5 -> {0,1,x}. Broadcast cdb_device=1, value=0x1234
//     -> same cycle read {1,0,0x1234}; next cycle stored ready, dbg_value=0x1234.
//   - Issue $7 and $8 both pending on device 2; one broadcast value=0xFF -> both ready with 0xFF;
//     all_ready=1 afterwards.
//   - WAW: $4 pending on device 1. In one cycle issue $4 on device 3 while the CDB broadcasts device 1
//     value=9 -> $4 reads {0,3,x}; dbg_value unchanged. Later device 3 broadcasts 0x40 -> $4=0x40.
//   - Register 0: issue to $0 on device 2 -> $0 still reads {1,0,0}; all_ready unaffected.
//   - Self-dependence: $1 pending on device 1; issue $1 again on device 2 reading rs=$1
//     -> rd_opnd_a={0,1,x} this cycle; $1 tag=2 next cycle.

Source files
------------

// File: rtl/tagged_register_file_pkg.sv
// Shared constants for the tagged register file: sizes, device numbers
// and the bit layout of a {ready, tag, value} operand.
package tagged_register_file_pkg;

  localparam int NREG_DEF   = 32;
  localparam int DATA_W_DEF = 32;
  localparam int TAG_W_DEF  = 3;
  localparam int ADDR_W     = 5;

  localparam logic [2:0] DEVICE_NONE  = 3'd0;
  localparam logic [2:0] DEVICE_ADDER = 3'd1;
  localparam logic [2:0] DEVICE_LOGIC = 3'd2;
  localparam logic [2:0] DEVICE_DM    = 3'd3;
  localparam logic [2:0] DEVICE_JMP   = 3'd7;

  localparam int OPND_READY    = 35;
  localparam int OPND_TAG_HI   = 34;
  localparam int OPND_TAG_LO   = 32;
  localparam int OPND_VALUE_HI = 31;
  localparam int OPND_VALUE_LO = 0;

endpackage

// File: rtl/tagged_register_file_entry.sv
// One architectural register with its Tomasulo status (ready, producer tag).
// Issue to this register beats a same-cycle retire: the older result is dead.
module reg_status_entry
  import tagged_register_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_hit,
  input  logic [TAG_W-1:0]  iss_device,
  input  logic              cdb_buzy,
  input  logic [TAG_W-1:0]  cdb_device,
  input  logic [DATA_W-1:0] cdb_value,
  output logic [DATA_W-1:0] value,
  output logic              ready,
  output logic [TAG_W-1:0]  tag
);

  logic [DATA_W-1:0] value_q, value_d;
  logic              ready_q, ready_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              retire_hit;

  assign retire_hit = cdb_buzy && (cdb_device != {TAG_W{1'b0}}) &&
                      !ready_q && (tag_q == cdb_device);

  // Next-state: issue, else retire, else hold.
  always_comb begin
    value_d = value_q;
    ready_d = ready_q;
    tag_d   = tag_q;
    if (iss_hit) begin
      ready_d = 1'b0;
      tag_d   = iss_device;
    end else if (retire_hit) begin
      value_d = cdb_value;
      ready_d = 1'b1;
      tag_d   = {TAG_W{1'b0}};
    end else begin
      value_d = value_q;
    end
  end

  // Status and value registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= {DATA_W{1'b0}};
      ready_q <= 1'b1;
      tag_q   <= {TAG_W{1'b0}};
    end else begin
      value_q <= value_d;
      ready_q <= ready_d;
      tag_q   <= tag_d;
    end
  end

  assign value = value_q;
  assign ready = ready_q;
  assign tag   = tag_q;

endmodule

// File: rtl/tagged_register_file.sv
// Architectural register file with register-status tags, two forwarding
// read ports for issue, CDB snooping, a debug read port and a drain flag.
module tagged_register_file
  import tagged_register_file_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       rd_addr_a,
  input  logic [ADDR_W-1:0]       rd_addr_b,
  output logic [DATA_W+TAG_W:0]   rd_opnd_a,
  output logic [DATA_W+TAG_W:0]   rd_opnd_b,
  input  logic                    iss_valid,
  input  logic [ADDR_W-1:0]       iss_rd,
  input  logic [TAG_W-1:0]        iss_device,
  input  logic                    cdb_buzy,
  input  logic [TAG_W-1:0]        cdb_device,
  input  logic [DATA_W-1:0]       cdb_value,
  input  logic [ADDR_W-1:0]       dbg_addr,
  output logic [DATA_W-1:0]       dbg_value,
  output logic                    all_ready
);

  localparam int OPND_W = DATA_W + TAG_W + 1;

  logic [DATA_W-1:0] value_s [NREG];
  logic              ready_s [NREG];
  logic [TAG_W-1:0]  tag_s   [NREG];

  assign value_s[0] = {DATA_W{1'b0}};
  assign ready_s[0] = 1'b1;
  assign tag_s[0]   = {TAG_W{1'b0}};

  for (genvar i = 1; i < NREG; i++) begin : g_entry
    logic iss_hit_s;
    assign iss_hit_s = iss_valid && (iss_rd == i[ADDR_W-1:0]);

    reg_status_entry #(
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W)
    ) u_entry (
      .clk        (clk),
      .rst        (rst),
      .iss_hit    (iss_hit_s),
      .iss_device (iss_device),
      .cdb_buzy   (cdb_buzy),
      .cdb_device (cdb_device),
      .cdb_value  (cdb_value),
      .value      (value_s[i]),
      .ready      (ready_s[i]),
      .tag        (tag_s[i])
    );
  end

  // Forward the live broadcast so stations latching at this edge see it.
  function automatic logic [OPND_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic              ready,
    input logic [TAG_W-1:0]  tag,
    input logic [DATA_W-1:0] value,
    input logic              buzy,
    input logic [TAG_W-1:0]  dev,
    input logic [DATA_W-1:0] bus_value
  );
    logic [OPND_W-1:0] res;
    if (addr == {ADDR_W{1'b0}}) begin
      res = {1'b1, {TAG_W{1'b0}}, {DATA_W{1'b0}}};
    end else if (ready) begin
      res = {1'b1, {TAG_W{1'b0}}, value};
    end else if (buzy && (dev != {TAG_W{1'b0}}) && (dev == tag)) begin
      res = {1'b1, {TAG_W{1'b0}}, bus_value};
    end else begin
      res = {1'b0, tag, {DATA_W{1'b0}}};
    end
    return res;
  endfunction

  // Operand read ports.
  always_comb begin
    rd_opnd_a = read_port(rd_addr_a, ready_s[rd_addr_a], tag_s[rd_addr_a],
                          value_s[rd_addr_a], cdb_buzy, cdb_device, cdb_value);
    rd_opnd_b = read_port(rd_addr_b, ready_s[rd_addr_b], tag_s[rd_addr_b],
                          value_s[rd_addr_b], cdb_buzy, cdb_device, cdb_value);
  end

  // Drain flag from stored ready bits only.
  always_comb begin
    all_ready = 1'b1;
    for (int i = 0; i < NREG; i++) begin
      all_ready = all_ready & ready_s[i];
    end
  end

  assign dbg_value = value_s[dbg_addr];

endmodule

// File: tb/tb_tagged_register_file.sv
// Directed table-driven bench for tagged_register_file plus a hand-written
// asynchronous reset sequence.
module tb_tagged_register_file;

  logic        clk;
  logic        rst;
  logic [4:0]  rd_addr_a, rd_addr_b, iss_rd, dbg_addr;
  logic [35:0] rd_opnd_a, rd_opnd_b;
  logic        iss_valid, cdb_buzy, all_ready;
  logic [2:0]  iss_device, cdb_device;
  logic [31:0] cdb_value, dbg_value;

  int n_total;
  int n_pass;

  tagged_register_file dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_opnd_a  (rd_opnd_a),
    .rd_opnd_b  (rd_opnd_b),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .iss_device (iss_device),
    .cdb_buzy   (cdb_buzy),
    .cdb_device (cdb_device),
    .cdb_value  (cdb_value),
    .dbg_addr   (dbg_addr),
    .dbg_value  (dbg_value),
    .all_ready  (all_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [4:0]  ird;
    logic [2:0]  idev;
    logic        cb;
    logic [2:0]  cdev;
    logic [31:0] cval;
    logic [4:0]  aa;
    logic [4:0]  ab;
    logic [4:0]  dbg;
    logic [35:0] ea;
    logic [35:0] eb;
    logic [31:0] edbg;
    logic        eall;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [35:0] op(input logic r, input logic [2:0] t, input logic [31:0] v);
    return {r, t, v};
  endfunction

  function automatic vec_t mk(
    input logic iv, input logic [4:0] ird, input logic [2:0] idev,
    input logic cb, input logic [2:0] cdev, input logic [31:0] cval,
    input logic [4:0] aa, input logic [4:0] ab, input logic [4:0] dbg,
    input logic [35:0] ea, input logic [35:0] eb, input logic [31:0] edbg, input logic eall);
    vec_t v;
    v.iv = iv; v.ird = ird; v.idev = idev; v.cb = cb; v.cdev = cdev; v.cval = cval;
    v.aa = aa; v.ab = ab; v.dbg = dbg; v.ea = ea; v.eb = eb; v.edbg = edbg; v.eall = eall;
    return v;
  endfunction

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    iss_valid = 1'b0; iss_rd = 5'd0; iss_device = 3'd0;
    cdb_buzy = 1'b0; cdb_device = 3'd0; cdb_value = 32'd0;
    rd_addr_a = 5'd0; rd_addr_b = 5'd0; dbg_addr = 5'd0;
    n_total = 0; n_pass = 0;

    //             iv  ird    idev  cb   cdev  cval           aa     ab     dbg    exp_a                       exp_b                       exp_dbg         all
    vecs.push_back(mk(1'b0, 5'd0, 3'd0, 1'b0, 3'd0, 32'h0,       5'd0,  5'd5,  5'd5,  op(1'b1,3'd0,32'h0),    op(1'b1,3'd0,32'h0),    32'h0,    1'b1));
    vecs.push_back(mk(1'b1, 5'd5, 3'd1, 1'b0, 3'd0, 32'h0,       5'd5,  5'd0,  5'd5,  op(1'b1,3'd0,32'h0),    op(1'b1,3'd0,32'h0),    32'h0,    1'b1));
    vecs.push_back(mk(1'b0, 5'd0, 3'd0, 1'b0, 3'd0, 32'h0,       5'd5,  5'd0,  5'd5,  op(1'b0,3'd1,32'h0),    op(1'b1,3'd0,32'h0),    32'h0,    1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 3'd0, 1'b1, 3'd1, 32'h1234,    5'd5,  5'd5,  5'd5,  op(1'b1,3'd0,32'h1234), op(1'b1,3'd0,32'h1234), 32'h0,    1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 3'd0, 1'b0, 3'd0, 32'h0,       5'd5,  5'd0,  5'd5,  op(1'b1,3'd0,32'h1234), op(1'b1,3'd0,32'h0),    32'h1234, 1'b1));
    vecs.push_back(mk(1'b1, 5'd7, 3'd2, 1'b0, 3'd0, 32'h0,       5'd7,  5'd8,  5'd7,  op(1'b1,3'd0,32'h0),    op(1'b1,3'd0,32'h0),    32'h0,    1'b1));
    vecs.push_back(mk(1'b1, 5'd8, 3'd2, 1'b0, 3'd0, 32'h0,       5'd7,  5'd8,  5'd7,  op(1'b0,3'd2,32'h0),    op(1'b1,3'd0,32'h0),    32'h0,    1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 3'd0, 1'b1, 3'd2, 32'hFF,      5'd7,  5'd8,  5'd7,  op(1'b1,3'd0,32'hFF),   op(1'b1,3'd0,32'hFF),   32'h0,    1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 3'd0, 1'b0, 3'd0, 32'h0,       5'd7,  5'd8,  5'd8,  op(1'b1,3'd0,32'hFF),   op(1'b1,3'd0,32'hFF),   32'hFF,   1'b1));
    // WAW: issue $4 on device 3 while device 1 (its old producer) broadcasts
    vecs.push_back(mk(1'b1, 5'd4, 3'd1, 1'b0, 3'd0, 32'h0,       5'd4,  5'd5,  5'd4,  op(1'b1,3'd0,32'h0),    op(1'b1,3'd0,32'h1234), 32'h0,    1'b1));
    vecs.push_back(mk(1'b1, 5'd4, 3'd3, 1'b1, 3'd1, 32'h9,       5'd4,  5'd5,  5'd4,  op(1'b1,3'd0,32'h9),    op(1'b1,3'd0,32'h1234), 32'h0,    1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 3'd0, 1'b0, 3'd0, 32'h0,       5'd4,  5'd4,  5'd4,  op(1'b0,3'd3,32'h0),    op(1'b0,3'd3,32'h0),    32'h0,    1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 3'd0, 1'b1, 3'd3, 32'h40,      5'd4,  5'd7,  5'd4,  op(1'b1,3'd0,32'h40),   op(1'b1,3'd0,32'hFF),   32'h0,    1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 3'd0, 1'b0, 3'd0, 32'h0,       5'd4,  5'd0,  5'd4,  op(1'b1,3'd0,32'h40),   op(1'b1,3'd0,32'h0),    32'h40,   1'b1));
    // Register 0 ignores issue
    vecs.push_back(mk(1'b1, 5'd0, 3'd2, 1'b0, 3'd0, 32'h0,       5'd0,  5'd0,  5'd0,  op(1'b1,3'd0,32'h0),    op(1'b1,3'd0,32'h0),    32'h0,    1'b1));
    vecs.push_back(mk(1'b0, 5'd0, 3'd0, 1'b1, 3'd2, 32'hABCD,    5'd0,  5'd0,  5'd0,  op(1'b1,3'd0,32'h0),    op(1'b1,3'd0,32'h0),    32'h0,    1'b1));
    // Self-dependence on $1
    vecs.push_back(mk(1'b1, 5'd1, 3'd1, 1'b0, 3'd0, 32'h0,       5'd1,  5'd0,  5'd1,  op(1'b1,3'd0,32'h0),    op(1'b1,3'd0,32'h0),    32'h0,    1'b1));
    vecs.push_back(mk(1'b1, 5'd1, 3'd2, 1'b0, 3'd0, 32'h0,       5'd1,  5'd0,  5'd1,  op(1'b0,3'd1,32'h0),    op(1'b1,3'd0,32'h0),    32'h0,    1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 3'd0, 1'b0, 3'd0, 32'h0,       5'd1,  5'd1,  5'd1,  op(1'b0,3'd2,32'h0),    op(1'b0,3'd2,32'h0),    32'h0,    1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 3'd0, 1'b1, 3'd1, 32'h55,      5'd1,  5'd0,  5'd1,  op(1'b0,3'd2,32'h0),    op(1'b1,3'd0,32'h0),    32'h0,    1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 3'd0, 1'b1, 3'd2, 32'h77,      5'd1,  5'd0,  5'd1,  op(1'b1,3'd0,32'h77),   op(1'b1,3'd0,32'h0),    32'h0,    1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 3'd0, 1'b0, 3'd0, 32'h0,       5'd1,  5'd5,  5'd1,  op(1'b1,3'd0,32'h77),   op(1'b1,3'd0,32'h1234), 32'h77,   1'b1));
    // Illegal broadcast on device 0 is ignored
    vecs.push_back(mk(1'b0, 5'd0, 3'd0, 1'b1, 3'd0, 32'hDEAD,    5'd9,  5'd1,  5'd9,  op(1'b1,3'd0,32'h0),    op(1'b1,3'd0,32'h77),   32'h0,    1'b1));
    vecs.push_back(mk(1'b0, 5'd0, 3'd0, 1'b0, 3'd0, 32'h0,       5'd9,  5'd1,  5'd9,  op(1'b1,3'd0,32'h0),    op(1'b1,3'd0,32'h77),   32'h0,    1'b1));

    #12 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      iss_valid = vecs[i].iv; iss_rd = vecs[i].ird; iss_device = vecs[i].idev;
      cdb_buzy = vecs[i].cb; cdb_device = vecs[i].cdev; cdb_value = vecs[i].cval;
      rd_addr_a = vecs[i].aa; rd_addr_b = vecs[i].ab; dbg_addr = vecs[i].dbg;
      #2;
      check($sformatf("v%0d opnd_a", i), rd_opnd_a, vecs[i].ea);
      check($sformatf("v%0d opnd_b", i), rd_opnd_b, vecs[i].eb);
      check($sformatf("v%0d dbg_value", i), {4'd0, dbg_value}, {4'd0, vecs[i].edbg});
      check($sformatf("v%0d all_ready", i), {35'd0, all_ready}, {35'd0, vecs[i].eall});
    end

    // Asynchronous reset between edges while $3 is pending
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd3; iss_device = 3'd1;
    cdb_buzy = 1'b0; rd_addr_a = 5'd3; rd_addr_b = 5'd1; dbg_addr = 5'd1;
    @(negedge clk);
    iss_valid = 1'b0;
    #1;
    check("rst pre opnd_a", rd_opnd_a, op(1'b0, 3'd1, 32'h0));
    check("rst pre all_ready", {35'd0, all_ready}, 36'd0);
    #1 rst = 1'b1;
    #1;
    check("rst opnd_a", rd_opnd_a, op(1'b1, 3'd0, 32'h0));
    check("rst opnd_b", rd_opnd_b, op(1'b1, 3'd0, 32'h0));
    check("rst dbg_value", {4'd0, dbg_value}, 36'd0);
    check("rst all_ready", {35'd0, all_ready}, 36'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post rst opnd_a", rd_opnd_a, op(1'b1, 3'd0, 32'h0));
    check("post rst all_ready", {35'd0, all_ready}, 36'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
